wb_arbiter: RTL

Writeback arbiter and pending-write scoreboard that drives the register file's single write port. It accepts results from two producers, the single-cycle ALU and the variable-latency load/store unit, over valid/ready handshakes. It serialises those results into one registered write per cycle. It also tracks which architectural registers have an issued-but-not-yet-written producer, so the issue stage can stall on RAW/WAW hazards.

---
 rtl/cpu_pkg.sv | 14 +
 rtl/rr_arb2.sv | 46 ++++
 rtl/wb_arbiter.sv | 106 ++++++++++
 3 files changed

// File: rtl/cpu_pkg.sv
// Shared CPU definitions: datapath widths, register-file size and writeback source encoding.
package cpu_pkg;

    localparam int XLEN      = 32;
    localparam int NREG      = 32;
    localparam int REG_IDX_W = 5;

    // Writeback producers; also used as the round-robin pointer value.
    typedef enum logic {
        SRC_ALU = 1'b0,
        SRC_LSU = 1'b1
    } src_e;

endpackage

// File: rtl/rr_arb2.sv
// Two-requester round-robin arbiter. Bit 0 is the ALU and bit 1 is the LSU.
// A lone requester always wins. Under contention the pointer picks the winner.
// After every grant the pointer moves to the source that lost.
module rr_arb2
    import cpu_pkg::*;
(
    input  logic       clk,
    input  logic       rst,
    input  logic [1:0] req_i,
    output logic [1:0] gnt_o
);

    src_e rr_q;
    src_e rr_d;

    // Combinational grant from the current requests and the pointer.
    always_comb begin
        gnt_o = 2'b00;
        case (req_i)
            2'b01:   gnt_o = 2'b01;
            2'b10:   gnt_o = 2'b10;
            2'b11:   gnt_o = (rr_q == SRC_ALU) ? 2'b01 : 2'b10;
            default: gnt_o = 2'b00;
        endcase
    end

    // Point at the non-granted source after any transfer.
    always_comb begin
        rr_d = rr_q;
        if (gnt_o[0]) begin
            rr_d = SRC_LSU;
        end else if (gnt_o[1]) begin
            rr_d = SRC_ALU;
        end
    end

    // Pointer register. After reset the ALU is favoured.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            rr_q <= SRC_ALU;
        end else begin
            rr_q <= rr_d;
        end
    end

endmodule

// File: rtl/wb_arbiter.sv
// Writeback arbiter and pending-write scoreboard.
// ALU and LSU results are merged into one registered register-file write per cycle.
// The scoreboard records which registers still have an outstanding producer.
module wb_arbiter
    import cpu_pkg::*;
(
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 alu_valid,
    input  logic [REG_IDX_W-1:0] alu_rd,
    input  logic [XLEN-1:0]      alu_data,
    output logic                 alu_ready,
    input  logic                 lsu_valid,
    input  logic [REG_IDX_W-1:0] lsu_rd,
    input  logic [XLEN-1:0]      lsu_data,
    output logic                 lsu_ready,
    input  logic                 iss_valid,
    input  logic [REG_IDX_W-1:0] iss_rd,
    output logic                 wb_we,
    output logic [REG_IDX_W-1:0] wb_rd,
    output logic [XLEN-1:0]      wb_wdata,
    output logic [NREG-1:0]      busy,
    output logic                 err
);

    logic [1:0]           gnt;
    logic                 acc;
    logic [REG_IDX_W-1:0] acc_rd;
    logic [XLEN-1:0]      acc_data;
    logic                 iss_set;
    logic                 clear_hit;

    logic                 wb_we_q,    wb_we_d;
    logic [REG_IDX_W-1:0] wb_rd_q,    wb_rd_d;
    logic [XLEN-1:0]      wb_wdata_q, wb_wdata_d;
    logic [NREG-1:0]      busy_q,     busy_d;
    logic                 err_q,      err_d;

    rr_arb2 u_arb (
        .clk   (clk),
        .rst   (rst),
        .req_i ({lsu_valid, alu_valid}),
        .gnt_o (gnt)
    );

    assign alu_ready = gnt[0];
    assign lsu_ready = gnt[1];

    // Select the accepted result. At most one source is granted per cycle.
    always_comb begin
        acc      = |gnt;
        acc_rd   = gnt[1] ? lsu_rd   : alu_rd;
        acc_data = gnt[1] ? lsu_data : alu_data;
    end

    // Next state for the write port, the scoreboard and the sticky error flag.
    always_comb begin
        wb_we_d    = acc && (acc_rd != '0);
        wb_rd_d    = wb_rd_q;
        wb_wdata_d = wb_wdata_q;
        if (acc) begin
            wb_rd_d    = acc_rd;
            wb_wdata_d = acc_data;
        end

        iss_set   = iss_valid && (iss_rd != '0);
        clear_hit = wb_we_q && (wb_rd_q == iss_rd);

        busy_d = busy_q;
        if (wb_we_q) begin
            busy_d[wb_rd_q] = 1'b0;
        end
        if (iss_set) begin
            busy_d[iss_rd] = 1'b1;
        end
        busy_d[0] = 1'b0;

        err_d = err_q
              | (iss_set && busy_q[iss_rd] && !clear_hit)
              | (wb_we_d && !busy_q[acc_rd]);
    end

    // State registers. Reset drops in-flight writes and pending busy bits.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            wb_we_q    <= 1'b0;
            wb_rd_q    <= '0;
            wb_wdata_q <= '0;
            busy_q     <= '0;
            err_q      <= 1'b0;
        end else begin
            wb_we_q    <= wb_we_d;
            wb_rd_q    <= wb_rd_d;
            wb_wdata_q <= wb_wdata_d;
            busy_q     <= busy_d;
            err_q      <= err_d;
        end
    end

    assign wb_we    = wb_we_q;
    assign wb_rd    = wb_rd_q;
    assign wb_wdata = wb_wdata_q;
    assign busy     = busy_q;
    assign err      = err_q;

endmodule
